// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
// Four requesters; IDLE -> GRANT -> COMMIT handshake per write.
module reg_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         grant,
  output logic               ack,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic [7:0]         wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COMMIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nx;
  logic [1:0]       owner_nx;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] q_nx;
  logic [7:0]       cnt_nx;

  // Scan from the far end so the slot closest to ptr wins last.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    q_nx     = q;
    cnt_nx   = wr_count;
    unique case (state)
      IDLE: begin
        if (|req) begin
          owner_nx = win;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (req[owner]) begin
          q_nx     = wdata[int'(owner)*WIDTH +: WIDTH];
          cnt_nx   = wr_count + 8'd1;
          state_nx = COMMIT;
        end else begin
          state_nx = IDLE;
        end
      end
      COMMIT: begin
        ptr_nx   = owner + 2'd1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      q        <= '0;
      wr_count <= 8'd0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      q        <= q_nx;
      wr_count <= cnt_nx;
    end
  end

  // Outputs decode only state and owner.
  always_comb begin
    grant = 4'b0000;
    if (state == GRANT) grant[owner] = 1'b1;
  end

  assign ack  = (state == COMMIT);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter.
// One task per scenario, hand-computed expectations.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic        ack;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  wr_count;

  int checks;
  int errors;

  logic [3:0] exp_g [5];
  logic [7:0] exp_q [5];

  reg_write_arbiter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .grant    (grant),
    .ack      (ack),
    .owner    (owner),
    .busy     (busy),
    .q        (q),
    .wr_count (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0000;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = 4'b0000;
    wdata = 32'h0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || wr_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: q=%h cnt=%h want 00 00", q, wr_count);
    end
    checks++;
    if (grant !== 4'b0000 || ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: grant=%b ack=%b busy=%b want 0000 0 0",
               grant, ack, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b owner=%0d want 0 0", busy, owner);
    end
  endtask

  task automatic test_single;
    wdata = 32'h0000_00A5;
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b ack=%b want 0001 1 0",
               grant, busy, ack);
    end
    tick();
    checks++;
    if (ack !== 1'b1 || q !== 8'hA5 || wr_count !== 8'd1 || grant !== 4'b0) begin
      errors++;
      $display("FAIL single_commit: ack=%b q=%h cnt=%0d grant=%b want 1 a5 1 0000",
               ack, q, wr_count, grant);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || q !== 8'hA5) begin
      errors++;
      $display("FAIL single_idle: busy=%b ack=%b q=%h want 0 0 a5", busy, ack, q);
    end
  endtask

  task automatic test_fairness;
    do_reset();
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    wdata = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (grant !== exp_g[i]) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got %b want %b", i, grant, exp_g[i]);
      end
      tick();
      checks++;
      if (ack !== 1'b1 || q !== exp_q[i]) begin
        errors++;
        $display("FAIL fair_commit[%0d]: ack=%b q=%h want 1 %h",
                 i, ack, q, exp_q[i]);
      end
      tick();
    end
    req = 4'b0000;
    checks++;
    if (wr_count !== 8'd5) begin
      errors++;
      $display("FAIL fair_count: got %0d want 5", wr_count);
    end
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    wdata = {8'h5C, 8'h77, 8'h00, 8'h00};
    req = 4'b1000;
    tick();
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL abort_grant: got %b want 0100", grant);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ack=%b want 0 0", busy, ack);
    end
    tick();
    checks++;
    if (ack !== 1'b0 || q !== 8'h5C || wr_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_nowrite: ack=%b q=%h cnt=%0d want 0 5c 1",
               ack, q, wr_count);
    end
    req = 4'b1100;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL abort_ptr: got %b want 0100", grant);
    end
    tick();
    checks++;
    if (ack !== 1'b1 || q !== 8'h77 || wr_count !== 8'd2) begin
      errors++;
      $display("FAIL abort_retry: ack=%b q=%h cnt=%0d want 1 77 2",
               ack, q, wr_count);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_grant;
    do_reset();
    wdata = {8'h44, 8'h33, 8'hFF, 8'h00};
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL rstg_grant: got %b want 0010", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || grant !== 4'b0 || ack !== 1'b0 || busy !== 1'b0
        || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL rstg_async: q=%h grant=%b ack=%b busy=%b cnt=%0d want 00 0000 0 0 0",
               q, grant, ack, busy, wr_count);
    end
    tick();
    checks++;
    if (ack !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL rstg_hold: ack=%b q=%h want 0 00", ack, q);
    end
    rst = 1'b0;
    req = 4'b1010;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL rstg_ptr: got %b want 0010", grant);
    end
    tick();
    checks++;
    if (ack !== 1'b1 || q !== 8'hFF || wr_count !== 8'd1) begin
      errors++;
      $display("FAIL rstg_commit: ack=%b q=%h cnt=%0d want 1 ff 1",
               ack, q, wr_count);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_counter_wrap;
    int nacks;
    nacks = 0;
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      wdata = {24'h0, 8'(i) ^ 8'h5A};
      tick();
      tick();
      if (ack === 1'b1) nacks++;
      if (i == 254) begin
        checks++;
        if (wr_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d want 255", wr_count);
        end
      end
      tick();
    end
    req = 4'b0000;
    checks++;
    if (nacks != 256) begin
      errors++;
      $display("FAIL wrap_acks: got %0d want 256", nacks);
    end
    checks++;
    if (wr_count !== 8'd0 || q !== 8'hA5) begin
      errors++;
      $display("FAIL wrap_final: cnt=%0d q=%h want 0 a5", wr_count, q);
    end
    tick();
    tick();
    checks++;
    if (q !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_hold: q=%h busy=%b want a5 0", q, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_reset_grant();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
